pipe_addsub: RTL
================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal: 8..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in cycles (legal: 1..4; WIDTH divisible by STAGES).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand, two's complement.
REQ-008 SHALL have port b  input  WIDTH  second operand, two's complement.
REQ-009 SHALL have port op  input  2  mode: 00 add, 01 sub, 10 signed saturating add, 11 signed saturating sub.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port s  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of MSB (pre-saturation).
REQ-014 SHALL have ports N, V, Z  output  1 each  negative, signed overflow, zero flags of s.

Function
REQ-015 Beat accepted on a clk edge where in_valid && in_ready; result emitted on a clk edge where out_valid && out_ready.
REQ-016 Sub modes compute a + ~b + 1; add modes compute a + b + 0; cout is the carry from that sum (sub: cout=1 means no borrow).
REQ-017 Sum is segmented: stage k (0..STAGES-1) adds bit slice [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES] using the registered carry from stage k-1; upper operand slices and op travel alongside, lower result slices ride forward.
REQ-018 V = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b or ~b per mode; V reports overflow even in saturating modes.
REQ-019 Saturating modes with V=1: s = 0x7F..F if a_msb=0, else 0x80..0; otherwise s = raw sum.
REQ-020 N = s[WIDTH-1], Z = (s == 0), both computed on the final (post-saturation) s.
REQ-021 Latency: with out_ready held high, out_valid for a beat asserts exactly STAGES cycles after its accepting edge.
REQ-022 Throughput: one beat per cycle sustained while out_ready is high; in_ready high whenever the stage-0 register is empty or advancing.
REQ-023 Each stage holds a valid bit; stage k advances when stage k+1 is empty or advancing; final stage advances when out_ready high.
REQ-024 out_ready low: pipeline fills, in_ready drops once all STAGES registers are valid and no beat is lost, duplicated or reordered.
REQ-025 s, cout, N, V, Z SHALL be stable while out_valid && !out_ready.
REQ-026 in_ready SHALL NOT depend combinationally on in_valid; it MAY depend combinationally on out_ready.
REQ-027 Simultaneous accept and emit on a full pipeline SHALL be allowed without bubble.
REQ-028 Outputs s, cout, N, V, Z are don't-care while out_valid=0 but SHALL hold their last registered value (no X after reset).

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits; out_valid=0, s=0, cout=0, N=0, V=0, Z=0 while rst_n low.
REQ-030 in_ready SHALL be 0 while rst_n low and 1 on the first edge after rst_n high.
REQ-031 Reset mid-operation discards all in-flight beats; no result from pre-reset beats appears afterward.

Verification (WIDTH=16, STAGES=2)
REQ-032 op=00, a=0x7FFF, b=0x0001, out_ready=1 -> 2 cycles later s=0x8000, cout=0, N=1, V=1, Z=0.
REQ-033 op=10, a=0x7FFF, b=0x0001 -> s=0x7FFF, V=1, N=0; op=11, a=0x8000, b=0x0001 -> s=0x8000, V=1, N=1.
REQ-034 op=01, a=0x0005, b=0x0005 -> s=0x0000, cout=1, Z=1, V=0; op=00, a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, Z=1, V=0.
REQ-035 out_ready=0, present 3 back-to-back beats (1+1, 2+2, 3+3) -> in_ready=0 after 2 accepted; raise out_ready -> outputs 0x0002, 0x0004, 0x0006 in order, one per cycle.
REQ-036 Stream 8 random beats with random out_ready -> every result matches reference model, count and order preserved, outputs stable during stall.
REQ-037 Assert rst_n low with 2 beats in flight -> out_valid=0 at once; after release, no stale result emitted, next beat returns after 2 cycles.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined add/sub with optional signed saturation. The carry chain is cut into
// STAGES equal slices, one slice resolved per stage, with valid/ready flow control.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             N,
  output logic             V,
  output logic             Z
);

  localparam int SL = WIDTH / STAGES;

  logic [STAGES-1:0] vld_q, vld_d, ld, take;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d, n_q, n_d, v_q, v_d, z_q, z_d;

  // Stage i may load when some stage at or after i is empty, or the tail drains.
  always_comb begin
    ld    = '0;
    take  = '0;
    vld_d = vld_q;
    en_d  = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      ld[i] = out_ready || ((vld_q >> i) != ({STAGES{1'b1}} >> i));
    end
    in_ready = en_q && ld[0];
    take[0]  = in_valid && in_ready;
    for (int i = 1; i < STAGES; i++) begin
      take[i] = ld[i] && vld_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (ld[i]) vld_d[i] = take[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      en_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      en_q  <= en_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SL;
    localparam int HI = LO + SL - 1;

    logic [SL-1:0] a_sl, b_sl;
    logic [HI:0]   raw;
    logic          c_in, sat_in;
    logic [SL:0]   part;

    if (k == 0) begin : g_src
      assign a_sl   = a[HI:0];
      assign b_sl   = op[0] ? ~b[HI:0] : b[HI:0];
      assign c_in   = op[0];
      assign sat_in = op[1];
      assign raw    = part[SL-1:0];
    end else begin : g_src
      assign a_sl   = g_stg[k-1].g_mid.au_q[HI:LO];
      assign b_sl   = g_stg[k-1].g_mid.bu_q[HI:LO];
      assign c_in   = g_stg[k-1].g_mid.c_q;
      assign sat_in = g_stg[k-1].g_mid.sat_q;
      assign raw    = {part[SL-1:0], g_stg[k-1].g_mid.sum_q};
    end

    assign part = {1'b0, a_sl} + {1'b0, b_sl} + {{SL{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_mid
      logic [HI:0]         sum_q, sum_d;
      logic [WIDTH-1:HI+1] au_q, au_d, bu_q, bu_d, au_in, bu_in;
      logic                c_q, c_d, sat_q, sat_d;

      // Upper operand slices (b already conditioned) travel with the partial sum.
      if (k == 0) begin : g_up
        assign au_in = a[WIDTH-1:HI+1];
        assign bu_in = op[0] ? ~b[WIDTH-1:HI+1] : b[WIDTH-1:HI+1];
      end else begin : g_up
        assign au_in = g_stg[k-1].g_mid.au_q[WIDTH-1:HI+1];
        assign bu_in = g_stg[k-1].g_mid.bu_q[WIDTH-1:HI+1];
      end

      always_comb begin
        sum_d = sum_q;
        au_d  = au_q;
        bu_d  = bu_q;
        c_d   = c_q;
        sat_d = sat_q;
        if (take[k]) begin
          sum_d = raw;
          au_d  = au_in;
          bu_d  = bu_in;
          c_d   = part[SL];
          sat_d = sat_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= '0;
          au_q  <= '0;
          bu_q  <= '0;
          c_q   <= 1'b0;
          sat_q <= 1'b0;
        end else begin
          sum_q <= sum_d;
          au_q  <= au_d;
          bu_q  <= bu_d;
          c_q   <= c_d;
          sat_q <= sat_d;
        end
      end
    end else begin : g_last
      logic             v_new;
      logic [WIDTH-1:0] s_new;

      // Output registers only load on a real beat so they hold through bubbles.
      always_comb begin
        v_new = (a_sl[SL-1] == b_sl[SL-1]) && (raw[WIDTH-1] != a_sl[SL-1]);
        s_new = raw;
        if (sat_in && v_new) begin
          s_new = a_sl[SL-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        s_d    = s_q;
        cout_d = cout_q;
        n_d    = n_q;
        v_d    = v_q;
        z_d    = z_q;
        if (take[k]) begin
          s_d    = s_new;
          cout_d = part[SL];
          n_d    = s_new[WIDTH-1];
          v_d    = v_new;
          z_d    = (s_new == '0);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q    <= '0;
          cout_q <= 1'b0;
          n_q    <= 1'b0;
          v_q    <= 1'b0;
          z_q    <= 1'b0;
        end else begin
          s_q    <= s_d;
          cout_q <= cout_d;
          n_q    <= n_d;
          v_q    <= v_d;
          z_q    <= z_d;
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign s         = s_q;
  assign cout      = cout_q;
  assign N         = n_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule
